bcd_scan_counter: RTL and testbench

//  Downstream consumer of the ClkRedu slow-tick output. Synchronizes the slow tick

---
 rtl/bcd_scan_counter.sv | 163 ++++++++++++++++
 tb/tb_bcd_scan_counter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_scan_counter.sv
// rtl/bcd_scan_counter.sv - 4-digit BCD up/down event counter with multiplexed 7-segment scan
//
// Purpose: synchronizes an asynchronous slow tick, counts its rising edges on a
// 0000-9999 BCD up/down counter and drives a multiplexed active-low display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank digits above the most
// significant nonzero digit; d0 always shown).
//
// Ports:
//   clk        in   system clock, all state on rising edge
//   reset      in   asynchronous active-low reset
//   tick_in    in   asynchronous slow tick, rising edge = one count event
//   run        in   1 = count events, 0 = discard them
//   up_down    in   1 = increment, 0 = decrement
//   clear      in   synchronous clear to 0000 (wins over a coincident event)
//   count_bcd  out  {d3,d2,d1,d0}
//   wrap       out  one-cycle pulse on 9999->0000 or 0000->9999
//   seg        out  {g,f,e,d,c,b,a} active-low, registered
//   an         out  one-hot active-low digit enable, registered, an[0] = d0

module bcd_scan_counter #(
  parameter int SCAN_DIV = 50000,
  parameter int SCAN_W   = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_in,
  input  logic        run,
  input  logic        up_down,
  input  logic        clear,
  output logic [15:0] count_bcd,
  output logic        wrap,
  output logic [6:0]  seg,
  output logic [3:0]  an
);

  logic              s1_q, s2_q, s3_q;
  logic              tick_evt;
  logic [15:0]       count_q, count_d;
  logic              wrap_q, wrap_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              carry;
  logic [3:0]        digit;
  logic [3:0]        cur_digit;
  logic              blank;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  // Rising edge of the synchronized tick; s3 resets low so a tick already high
  // at reset release still counts once.
  assign tick_evt = s2_q & ~s3_q;

  // Digit-wise ripple carry/borrow keeps every digit in 0-9 without a binary form.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    carry   = 1'b0;
    digit   = 4'd0;
    if (clear) begin
      count_d = 16'h0000;
    end else if (tick_evt && run) begin
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
        digit = count_q[4*i +: 4];
        if (carry) begin
          if (up_down) begin
            if (digit == 4'd9) begin
              count_d[4*i +: 4] = 4'd0;
            end else begin
              count_d[4*i +: 4] = digit + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (digit == 4'd0) begin
              count_d[4*i +: 4] = 4'd9;
            end else begin
              count_d[4*i +: 4] = digit - 4'd1;
              carry = 1'b0;
            end
          end
        end
      end
      // Carry/borrow out of d3 means the counter wrapped.
      wrap_d = carry;
    end
  end

  always_comb begin
    scan_d = scan_q + {{(SCAN_W-1){1'b0}}, 1'b1};
    idx_d  = idx_q;
    if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = idx_q + 2'd1;
    end
  end

  assign cur_digit = count_q[{idx_q, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [1:0] msd;
  always_comb begin
    msd = 2'd0;
    if (count_q[15:12] != 4'd0)     msd = 2'd3;
    else if (count_q[11:8] != 4'd0) msd = 2'd2;
    else if (count_q[7:4] != 4'd0)  msd = 2'd1;
  end
  // idx 0 can never exceed msd, so d0 is never blanked.
  assign blank = (idx_q > msd);
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = ~(4'b0001 << idx_q);
    seg_d = blank ? 7'b1111111 : seg_decode(cur_digit);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      count_q <= 16'h0000;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= 2'd0;
      an_q    <= 4'b1111;
      seg_q   <= 7'b1111111;
    end else begin
      s1_q    <= tick_in;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  assign count_bcd = count_q;
  assign wrap      = wrap_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// tb/tb_bcd_scan_counter.sv - randomized self-checking bench for bcd_scan_counter

module tb_bcd_scan_counter;

  localparam int SDIV = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tick_in = 1'b0;
  logic        run = 1'b0;
  logic        up_down = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] count_bcd;
  logic        wrap;
  logic [6:0]  seg;
  logic [3:0]  an;

  int errors = 0;
  int checks = 0;
  int model  = 0;
  int cyc    = 0;

  logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

  bcd_scan_counter #(.SCAN_DIV(SDIV), .SCAN_W(16)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .run(run), .up_down(up_down),
    .clear(clear), .count_bcd(count_bcd), .wrap(wrap), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset)
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int idx);
    int pw;
    int d;
    int top;
    pw  = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
    d   = (v / pw) % 10;
    top = (v >= 1000) ? 3 : (v >= 100) ? 2 : (v >= 10) ? 1 : 0;
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > top) return 7'b1111111;
`endif
    if (top < 0) return 7'b1111111;
    return seg_tab[d];
  endfunction

  task automatic do_event(input logic r, input logic ud, input logic clr);
    int  old;
    logic exp_wrap;
    @(negedge clk) tick_in = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("count_before_e2", count_bcd, to_bcd(model));
    @(negedge clk) begin run = r; up_down = ud; clear = clr; end
    old = model;
    exp_wrap = 1'b0;
    if (clr) model = 0;
    else if (r && ud) begin model = (model + 1) % 10000; exp_wrap = (old == 9999); end
    else if (r) begin model = (model + 9999) % 10000; exp_wrap = (old == 0); end
    @(posedge clk);
    #1 chk("count_at_e2", count_bcd, to_bcd(model));
    chk("wrap_at_e2", wrap, exp_wrap);
    @(negedge clk) begin tick_in = 1'b0; clear = 1'b0; end
    @(posedge clk);
    #1 chk("wrap_one_cycle", wrap, 1'b0);
    chk("count_hold", count_bcd, to_bcd(model));
    repeat (2) @(posedge clk);
  endtask

  task automatic scan_check(input int ncyc);
    int idx;
    logic [3:0] exp_an;
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      idx = ((cyc - 1) / SDIV) % 4;
      exp_an = ~(4'b0001 << idx);
      chk("an_scan", an, exp_an);
      chk("seg_scan", seg, exp_seg(model, idx));
    end
  endtask

  task automatic goto_value(input int target);
    int dist_up;
    while (model != target) begin
      dist_up = (target - model + 10000) % 10000;
      do_event(1'b1, dist_up <= 5000, 1'b0);
    end
    chk("goto_value", count_bcd, to_bcd(target));
  endtask

  initial begin
    // Held in reset with tick_in toggling: everything stays at reset values.
    repeat (8) begin
      @(negedge clk) tick_in = ~tick_in;
      @(posedge clk);
      #1 chk("rst_count", count_bcd, 16'h0000);
      chk("rst_wrap", wrap, 1'b0);
      chk("rst_an", an, 4'b1111);
      chk("rst_seg", seg, 7'b1111111);
    end
    @(negedge clk) begin tick_in = 1'b0; reset = 1'b1; end
    @(posedge clk);
    #1 chk("first_an", an, 4'b1110);
    chk("first_seg", seg, 7'b1000000);

    // Ten up events from 0000 end at 0010.
    for (int i = 0; i < 10; i++) do_event(1'b1, 1'b1, 1'b0);
    chk("ten_events", count_bcd, 16'h0010);

    // Clear coincident with an event, then discarded events with run=0.
    do_event(1'b1, 1'b1, 1'b1);
    do_event(1'b1, 1'b1, 1'b0);
    do_event(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) do_event(1'b0, $urandom_range(0, 1), 1'b0);
    chk("run0_hold", count_bcd, 16'h0002);

    // Idle clear with no event.
    @(negedge clk) clear = 1'b1;
    @(posedge clk);
    #1 chk("idle_clear", count_bcd, 16'h0000);
    model = 0;
    @(negedge clk) clear = 1'b0;

    // Both wrap directions.
    do_event(1'b1, 1'b0, 1'b0);
    chk("down_wrap", count_bcd, 16'h9999);
    do_event(1'b1, 1'b1, 1'b0);
    chk("up_wrap", count_bcd, 16'h0000);

    // Random events interleaved with scan checks.
    for (int i = 0; i < 60; i++) begin
      do_event($urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7) == 0);
      if (i % 10 == 9) scan_check(6);
    end

    goto_value(1234);
    scan_check(40);
    goto_value(42);
    scan_check(24);
    goto_value(0);
    scan_check(24);
    goto_value(9990);
    scan_check(16);

    // Asynchronous reset mid-count, released with tick_in high: counts once.
    @(posedge clk);
    #3 reset = 1'b0;
    #1 chk("async_count", count_bcd, 16'h0000);
    chk("async_an", an, 4'b1111);
    chk("async_seg", seg, 7'b1111111);
    chk("async_wrap", wrap, 1'b0);
    model = 0;
    @(negedge clk) begin tick_in = 1'b1; run = 1'b1; up_down = 1'b1; clear = 1'b0; end
    @(negedge clk) reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 chk("rel_tick_e2", count_bcd, 16'h0000);
    @(posedge clk);
    #1 chk("rel_tick_counts", count_bcd, 16'h0001);
    model = 1;
    repeat (3) @(posedge clk);
    #1 chk("rel_tick_once", count_bcd, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
